// File: rtl/axi4_mem_responder_if.sv
// AXI4 slave-side bundle for the memory responder: AW/W/B/AR/R channels
// with a master modport for the requester and a slave modport for the responder.
interface axi4_mem_responder_if #(
  parameter int ID_W   = 6,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512
);
  logic [ID_W-1:0]     s_axi_awid;
  logic [ADDR_W-1:0]   s_axi_awaddr;
  logic [7:0]          s_axi_awlen;
  logic [2:0]          s_axi_awsize;
  logic [1:0]          s_axi_awburst;
  logic                s_axi_awvalid;
  logic                s_axi_awready;

  logic [DATA_W-1:0]   s_axi_wdata;
  logic [DATA_W/8-1:0] s_axi_wstrb;
  logic                s_axi_wlast;
  logic                s_axi_wvalid;
  logic                s_axi_wready;

  logic [ID_W-1:0]     s_axi_bid;
  logic [1:0]          s_axi_bresp;
  logic                s_axi_bvalid;
  logic                s_axi_bready;

  logic [ID_W-1:0]     s_axi_arid;
  logic [ADDR_W-1:0]   s_axi_araddr;
  logic [7:0]          s_axi_arlen;
  logic [2:0]          s_axi_arsize;
  logic [1:0]          s_axi_arburst;
  logic                s_axi_arvalid;
  logic                s_axi_arready;

  logic [ID_W-1:0]     s_axi_rid;
  logic [DATA_W-1:0]   s_axi_rdata;
  logic [1:0]          s_axi_rresp;
  logic                s_axi_rlast;
  logic                s_axi_rvalid;
  logic                s_axi_rready;

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready
  );

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready
  );
endinterface

// File: rtl/axi4_mem_responder.sv
// Single-outstanding AXI4 responder backed by MEM_DEPTH x DATA_W register storage.
// Full-width INCR bursts only; out-of-range addresses answer DECERR, other bursts SLVERR.
module axi4_mem_responder #(
  parameter int ID_W      = 6,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 512,
  parameter int MEM_DEPTH = 256
) (
  input  logic clk,
  input  logic rst_n,
  axi4_mem_responder_if.slave axi
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [ID_W-1:0]   id_q;
  logic [IDX_W-1:0]  idx_q;
  logic [7:0]        len_q;
  logic [7:0]        cnt_q;
  logic [1:0]        resp_q;
  logic              ready_en;

  logic aw_rdy, ar_rdy, w_rdy, b_vld, r_vld;
  logic aw_hs, ar_hs, w_hs, b_hs, r_hs;
  logic cnt_done, w_final, r_final;
  logic unused_ok;

  // DECERR wins over SLVERR when both apply.
  function automatic logic [1:0] decode_resp(input logic [ADDR_W-1:0] addr,
                                             input logic [1:0]        burst);
    if (addr[ADDR_W-1:OFF_W+IDX_W] != '0) return RESP_DECERR;
    if (burst != BURST_INCR)              return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  // ready_en keeps the address channels closed until the first edge after reset release.
  assign aw_rdy = (state == IDLE) && ready_en;
  assign ar_rdy = (state == IDLE) && ready_en && !axi.s_axi_awvalid;
  assign w_rdy  = (state == WDATA);
  assign b_vld  = (state == WRESP);
  assign r_vld  = (state == RDATA);

  assign aw_hs    = axi.s_axi_awvalid && aw_rdy;
  assign ar_hs    = axi.s_axi_arvalid && ar_rdy;
  assign w_hs     = axi.s_axi_wvalid  && w_rdy;
  assign b_hs     = axi.s_axi_bready  && b_vld;
  assign r_hs     = axi.s_axi_rready  && r_vld;
  assign cnt_done = (cnt_q == len_q);
  assign w_final  = w_hs && (cnt_done || axi.s_axi_wlast);
  assign r_final  = r_hs && cnt_done;

  assign axi.s_axi_awready = aw_rdy;
  assign axi.s_axi_arready = ar_rdy;
  assign axi.s_axi_wready  = w_rdy;
  assign axi.s_axi_bvalid  = b_vld;
  assign axi.s_axi_bid     = id_q;
  assign axi.s_axi_bresp   = resp_q;
  assign axi.s_axi_rvalid  = r_vld;
  assign axi.s_axi_rid     = id_q;
  assign axi.s_axi_rresp   = resp_q;
  assign axi.s_axi_rlast   = r_vld && cnt_done;
  assign axi.s_axi_rdata   = (r_vld && resp_q == RESP_OKAY) ? mem[idx_q] : '0;

  assign unused_ok = ^{axi.s_axi_awsize, axi.s_axi_arsize,
                       axi.s_axi_awaddr[OFF_W-1:0], axi.s_axi_araddr[OFF_W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (aw_hs)      state_nxt = WDATA;
        else if (ar_hs) state_nxt = RDATA;
      end
      WDATA:   if (w_final) state_nxt = WRESP;
      WRESP:   if (b_hs)    state_nxt = IDLE;
      RDATA:   if (r_final) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      id_q     <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      resp_q   <= RESP_OKAY;
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE: begin
          if (aw_hs) begin
            id_q   <= axi.s_axi_awid;
            idx_q  <= axi.s_axi_awaddr[OFF_W +: IDX_W];
            len_q  <= axi.s_axi_awlen;
            cnt_q  <= '0;
            resp_q <= decode_resp(axi.s_axi_awaddr, axi.s_axi_awburst);
          end else if (ar_hs) begin
            id_q   <= axi.s_axi_arid;
            idx_q  <= axi.s_axi_araddr[OFF_W +: IDX_W];
            len_q  <= axi.s_axi_arlen;
            cnt_q  <= '0;
            resp_q <= decode_resp(axi.s_axi_araddr, axi.s_axi_arburst);
          end
        end
        WDATA: begin
          if (w_hs) begin
            cnt_q <= cnt_q + 8'd1;
            idx_q <= idx_q + 1'b1;
            // Burst ended by only one of count/wlast: the master and slave disagree on length.
            if (w_final && resp_q == RESP_OKAY && (cnt_done != axi.s_axi_wlast))
              resp_q <= RESP_SLVERR;
          end
        end
        RDATA: begin
          if (r_hs) begin
            cnt_q <= cnt_q + 8'd1;
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately outside reset so completed beats survive it.
  always_ff @(posedge clk) begin
    if (w_hs && resp_q == RESP_OKAY) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi.s_axi_wstrb[b]) mem[idx_q][b*8 +: 8] <= axi.s_axi_wdata[b*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi4_mem_responder.sv
// Randomised bench for axi4_mem_responder against a byte-level array model of the memory.
module tb_axi4_mem_responder;
  localparam int ID_W      = 6;
  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 512;
  localparam int MEM_DEPTH = 256;
  localparam int BYTES     = DATA_W / 8;
  localparam longint MEM_BYTES = longint'(MEM_DEPTH) * BYTES;
  localparam logic [1:0] INCR = 2'b01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_mem_responder_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  axi4_mem_responder #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .axi   (axi)
  );

  logic [DATA_W-1:0] ref_mem [MEM_DEPTH];
  int total = 0;
  int bad   = 0;

  function automatic logic [1:0] exp_resp(input logic [ADDR_W-1:0] addr, input logic [1:0] burst);
    if (addr >= ADDR_W'(MEM_BYTES)) return 2'b11;
    if (burst != INCR) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int word_of(input logic [ADDR_W-1:0] addr, input int beat);
    return int'(((addr / BYTES) + ADDR_W'(beat)) % MEM_DEPTH);
  endfunction

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic idle_inputs();
    axi.s_axi_awid = '0; axi.s_axi_awaddr = '0; axi.s_axi_awlen = '0;
    axi.s_axi_awsize = 3'd6; axi.s_axi_awburst = INCR; axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wdata = '0; axi.s_axi_wstrb = '0; axi.s_axi_wlast = 1'b0; axi.s_axi_wvalid = 1'b0;
    axi.s_axi_bready = 1'b0;
    axi.s_axi_arid = '0; axi.s_axi_araddr = '0; axi.s_axi_arlen = '0;
    axi.s_axi_arsize = 3'd6; axi.s_axi_arburst = INCR; axi.s_axi_arvalid = 1'b0;
    axi.s_axi_rready = 1'b0;
  endtask

  task automatic do_aw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                       input int len, input logic [1:0] burst);
    int n = 0;
    axi.s_axi_awid = id; axi.s_axi_awaddr = addr; axi.s_axi_awlen = 8'(len);
    axi.s_axi_awburst = burst; axi.s_axi_awvalid = 1'b1;
    #1;
    while (!axi.s_axi_awready && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if ({axi.s_axi_awready, axi.s_axi_arready} !== 2'b10)
      begin bad++; $display("FAIL aw_accept awready/arready got=%b want=10", {axi.s_axi_awready, axi.s_axi_arready}); end
    @(posedge clk); #1;
    axi.s_axi_awvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                       input int len, input logic [1:0] burst);
    int n = 0;
    axi.s_axi_arid = id; axi.s_axi_araddr = addr; axi.s_axi_arlen = 8'(len);
    axi.s_axi_arburst = burst; axi.s_axi_arvalid = 1'b1;
    #1;
    while (!axi.s_axi_arready && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if (axi.s_axi_arready !== 1'b1) begin bad++; $display("FAIL ar_accept arready got=%b want=1", axi.s_axi_arready); end
    @(posedge clk); #1;
    axi.s_axi_arvalid = 1'b0;
  endtask

  task automatic do_write(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input int len,
                          input logic [1:0] burst, input int wlast_at, input logic [BYTES-1:0] strb,
                          input bit rand_strb, input int bdelay);
    logic [1:0]        er;
    logic [DATA_W-1:0] d;
    logic [BYTES-1:0]  s;
    int                end_beat, w;
    er = exp_resp(addr, burst);
    end_beat = (wlast_at < len) ? wlast_at : len;
    do_aw(id, addr, len, burst);
    for (int b = 0; b <= end_beat; b++) begin
      d = rand_word();
      s = rand_strb ? {$urandom, $urandom} : strb;
      axi.s_axi_wdata = d; axi.s_axi_wstrb = s;
      axi.s_axi_wlast = (b == wlast_at); axi.s_axi_wvalid = 1'b1;
      #1;
      total++;
      if ({axi.s_axi_wready, axi.s_axi_awready, axi.s_axi_arready} !== 3'b100)
        begin bad++; $display("FAIL w_beat%0d wready/awready/arready got=%b want=100", b,
                              {axi.s_axi_wready, axi.s_axi_awready, axi.s_axi_arready}); end
      @(posedge clk);
      if (er == 2'b00) begin
        w = word_of(addr, b);
        for (int k = 0; k < BYTES; k++) if (s[k]) ref_mem[w][k*8 +: 8] = d[k*8 +: 8];
      end
      #1;
    end
    axi.s_axi_wvalid = 1'b0; axi.s_axi_wlast = 1'b0;
    if (er == 2'b00 && wlast_at != len) er = 2'b10;
    total++;
    if ({axi.s_axi_bvalid, axi.s_axi_arready, axi.s_axi_wready} !== 3'b100)
      begin bad++; $display("FAIL b_timing bvalid/arready/wready got=%b want=100",
                            {axi.s_axi_bvalid, axi.s_axi_arready, axi.s_axi_wready}); end
    total++;
    if ({axi.s_axi_bid, axi.s_axi_bresp} !== {id, er})
      begin bad++; $display("FAIL b_resp bid=%0d bresp=%b want bid=%0d bresp=%b", axi.s_axi_bid, axi.s_axi_bresp, id, er); end
    for (int c = 0; c < bdelay; c++) begin
      @(posedge clk); #1;
      total++;
      if ({axi.s_axi_bvalid, axi.s_axi_bid, axi.s_axi_arready} !== {1'b1, id, 1'b0})
        begin bad++; $display("FAIL b_hold bvalid=%b bid=%0d arready=%b want 1/%0d/0", axi.s_axi_bvalid, axi.s_axi_bid, axi.s_axi_arready, id); end
    end
    axi.s_axi_bready = 1'b1;
    @(posedge clk); #1;
    axi.s_axi_bready = 1'b0;
    total++;
    if (axi.s_axi_bvalid !== 1'b0) begin bad++; $display("FAIL b_done bvalid got=%b want=0", axi.s_axi_bvalid); end
  endtask

  task automatic do_read(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input int len,
                         input logic [1:0] burst, input bit stall);
    logic [1:0]        er;
    logic [DATA_W-1:0] ed;
    logic [ID_W+DATA_W+2:0] cur, prev;
    bit  have_prev = 0;
    int  beat = 0, cycles = 0;
    er = exp_resp(addr, burst);
    do_ar(id, addr, len, burst);
    while (beat <= len && cycles < 500) begin
      axi.s_axi_rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      cur = {axi.s_axi_rid, axi.s_axi_rresp, axi.s_axi_rlast, axi.s_axi_rdata};
      total++;
      if (axi.s_axi_rvalid !== 1'b1) begin bad++; $display("FAIL r_valid beat%0d got=%b want=1", beat, axi.s_axi_rvalid); end
      if (have_prev) begin
        total++;
        if (cur !== prev) begin bad++; $display("FAIL r_stable beat%0d rid/rresp/rlast/rdata changed while stalled", beat); end
      end
      if (axi.s_axi_rready) begin
        ed = (er == 2'b00) ? ref_mem[word_of(addr, beat)] : '0;
        total++;
        if (cur !== {id, er, (beat == len), ed})
          begin bad++; $display("FAIL r_beat%0d rid=%0d rresp=%b rlast=%b rdata=%h want rid=%0d rresp=%b rlast=%b rdata=%h",
                                beat, axi.s_axi_rid, axi.s_axi_rresp, axi.s_axi_rlast, axi.s_axi_rdata, id, er, (beat == len), ed); end
        beat++;
        have_prev = 0;
      end else begin
        prev = cur;
        have_prev = 1;
      end
      @(posedge clk); #1;
      cycles++;
    end
    axi.s_axi_rready = 1'b0;
    total++;
    if (beat <= len) begin bad++; $display("FAIL r_timeout beats got=%0d want=%0d", beat, len + 1); end
    total++;
    if (axi.s_axi_rvalid !== 1'b0) begin bad++; $display("FAIL r_done rvalid got=%b want=0", axi.s_axi_rvalid); end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready, axi.s_axi_bvalid, axi.s_axi_rvalid, axi.s_axi_rlast} !== 6'b0)
      begin bad++; $display("FAIL reset_ctrl got=%b want=000000", {axi.s_axi_awready, axi.s_axi_wready,
                            axi.s_axi_arready, axi.s_axi_bvalid, axi.s_axi_rvalid, axi.s_axi_rlast}); end
    total++;
    if ({axi.s_axi_bid, axi.s_axi_bresp, axi.s_axi_rid, axi.s_axi_rresp, axi.s_axi_rdata} !== '0)
      begin bad++; $display("FAIL reset_data bid=%0d bresp=%b rid=%0d rresp=%b want all 0", axi.s_axi_bid, axi.s_axi_bresp, axi.s_axi_rid, axi.s_axi_rresp); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({axi.s_axi_awready, axi.s_axi_arready} !== 2'b11)
      begin bad++; $display("FAIL reset_release awready/arready got=%b want=11", {axi.s_axi_awready, axi.s_axi_arready}); end
  endtask

  task automatic test_init();
    do_write(6'd1, '0, MEM_DEPTH - 1, INCR, MEM_DEPTH - 1, '1, 1'b0, 0);
  endtask

  task automatic test_basic();
    do_write(6'd5, 64'h40, 3, INCR, 3, '1, 1'b0, 2);
    do_read(6'd7, 64'h40, 3, INCR, 1'b0);
  endtask

  task automatic test_strobe();
    do_write(6'd11, 64'(10 * BYTES), 0, INCR, 0, 64'h1, 1'b0, 0);
    do_read(6'd12, 64'(10 * BYTES), 0, INCR, 1'b0);
  endtask

  task automatic test_wrap();
    do_read(6'd3, 64'((MEM_DEPTH - 1) * BYTES), 1, INCR, 1'b0);
    do_write(6'd4, 64'((MEM_DEPTH - 2) * BYTES), 3, INCR, 3, '0, 1'b1, 0);
    do_read(6'd4, 64'((MEM_DEPTH - 2) * BYTES), 3, INCR, 1'b0);
  endtask

  task automatic test_collision();
    axi.s_axi_arid = 6'd21; axi.s_axi_araddr = 64'(50 * BYTES); axi.s_axi_arlen = 8'd1;
    axi.s_axi_arburst = INCR; axi.s_axi_arvalid = 1'b1;
    do_write(6'd20, 64'(50 * BYTES), 1, INCR, 1, '1, 1'b0, 1);
    total++;
    if ({axi.s_axi_awready, axi.s_axi_arready} !== 2'b11)
      begin bad++; $display("FAIL collide_ar_after_b awready/arready got=%b want=11", {axi.s_axi_awready, axi.s_axi_arready}); end
    do_read(6'd21, 64'(50 * BYTES), 1, INCR, 1'b0);
  endtask

  task automatic test_errors();
    do_read(6'd2, 64'h10000, 2, INCR, 1'b1);
    do_read(6'd2, MEM_BYTES + 64'h80, 0, 2'b10, 1'b0);
    do_read(6'd2, 64'(60 * BYTES), 1, 2'b00, 1'b0);
    do_write(6'd8, MEM_BYTES + 64'(5 * BYTES), 0, INCR, 0, '1, 1'b0, 0);
    do_write(6'd9, 64'(20 * BYTES), 1, 2'b00, 1, '1, 1'b0, 0);
    do_read(6'd10, 64'(5 * BYTES), 0, INCR, 1'b0);
    do_read(6'd10, 64'(20 * BYTES), 1, INCR, 1'b0);
  endtask

  task automatic test_stall_and_wlast();
    do_read(6'd13, 64'(70 * BYTES), 7, INCR, 1'b1);
    do_write(6'd14, 64'(30 * BYTES), 3, INCR, 1, '1, 1'b0, 0);
    do_write(6'd15, 64'(34 * BYTES), 2, INCR, 99, '1, 1'b0, 0);
    do_read(6'd16, 64'(30 * BYTES), 7, INCR, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] d;
    d = rand_word();
    do_aw(6'd9, 64'(40 * BYTES), 3, INCR);
    axi.s_axi_wdata = d; axi.s_axi_wstrb = '1; axi.s_axi_wlast = 1'b0; axi.s_axi_wvalid = 1'b1;
    @(posedge clk);
    ref_mem[40] = d;
    #3;
    rst_n = 1'b0;
    #1;
    axi.s_axi_wvalid = 1'b0;
    total++;
    if ({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready, axi.s_axi_bvalid, axi.s_axi_rvalid, axi.s_axi_rlast} !== 6'b0)
      begin bad++; $display("FAIL midreset_ctrl got=%b want=000000", {axi.s_axi_awready, axi.s_axi_wready,
                            axi.s_axi_arready, axi.s_axi_bvalid, axi.s_axi_rvalid, axi.s_axi_rlast}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({axi.s_axi_awready, axi.s_axi_bvalid} !== 2'b10)
      begin bad++; $display("FAIL midreset_release awready/bvalid got=%b want=10", {axi.s_axi_awready, axi.s_axi_bvalid}); end
    axi.s_axi_bready = 1'b1; axi.s_axi_rready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++;
      if ({axi.s_axi_bvalid, axi.s_axi_rvalid, axi.s_axi_wready} !== 3'b000)
        begin bad++; $display("FAIL midreset_no_resp bvalid/rvalid/wready got=%b want=000", {axi.s_axi_bvalid, axi.s_axi_rvalid, axi.s_axi_wready}); end
    end
    axi.s_axi_bready = 1'b0; axi.s_axi_rready = 1'b0;
    do_read(6'd9, 64'(40 * BYTES), 0, INCR, 1'b0);
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] addr;
    logic [1:0]        burst;
    int                len, sel;
    for (int t = 0; t < 16; t++) begin
      len   = $urandom_range(0, 7);
      sel   = $urandom_range(0, 9);
      addr  = 64'($urandom_range(0, MEM_DEPTH - 1) * BYTES) + 64'($urandom_range(0, BYTES - 1));
      burst = INCR;
      if (sel == 0) addr = addr + ADDR_W'(MEM_BYTES);
      if (sel == 1) burst = 2'($urandom_range(0, 1) * 2);
      if ($urandom_range(0, 1) == 1)
        do_write(6'($urandom), addr, len, burst, (sel == 2) ? $urandom_range(0, 9) : len, '0, 1'b1, $urandom_range(0, 2));
      else
        do_read(6'($urandom), addr, len, burst, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_basic();
    test_strobe();
    test_wrap();
    test_collision();
    test_errors();
    test_stall_and_wlast();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time budget total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
